branch_resolve_unit: RTL and testbench

Execute-stage block directly downstream of the branch decoder. It takes the decoded rs1/rs2 operand values, the 12-bit branch immediate and the 3-bit branch_control code, together with the branch PC. It evaluates the condition, computes the target and registers the result behind a valid/ready handshake. On a taken branch it issues a one-cycle fetch redirect, then squashes wrong-path input for a fixed shadow window. It also keeps saturating branch and taken statistics counters.

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_compare.sv | 26 ++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch condition encodings and resolve-stage FSM states
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLT  = 3'd4;
  localparam logic [2:0] BGE  = 3'd5;
  localparam logic [2:0] BLTU = 3'd6;
  localparam logic [2:0] BGEU = 3'd7;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition evaluation
module branch_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      branch_control,
  output logic            taken
);

  // Evaluate the condition; unlisted codes fall back to equality.
  always_comb begin
    taken = 1'b0;
    case (branch_control)
      BNE:     taken = (rs1 != rs2);
      BLT:     taken = ($signed(rs1) <  $signed(rs2));
      BGE:     taken = ($signed(rs1) >= $signed(rs2));
      BLTU:    taken = (rs1 <  rs2);
      BGEU:    taken = (rs1 >= rs2);
      default: taken = (rs1 == rs2);
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolve stage with redirect, shadow squash and statistics
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [11:0]      in_imm,
  input  logic [2:0]       in_branch_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_misalign,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int SCW = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);
  localparam logic [SCW-1:0] SHADOW_INIT = SCW'(SHADOW_CYCLES);

  br_state_e       state, state_nxt;
  logic [SCW-1:0]  shadow_cnt, shadow_cnt_nxt;
  logic            taken;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            take_in;
  logic            resolve;
  logic            do_redirect;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .rs1            (in_rs1_data),
    .rs2            (in_rs2_data),
    .branch_control (in_branch_control),
    .taken          (taken)
  );

  // Target is the branch PC plus the sign-extended halfword offset, wrapping.
  assign imm_ext     = {{(XLEN-13){in_imm[11]}}, in_imm, 1'b0};
  assign target      = in_pc + imm_ext;
  assign misalign    = taken & target[1];

  // SHADOW drains upstream unconditionally; RUN only back-pressures on a stalled result.
  assign in_ready    = (state == SHADOW) | ~out_valid | out_ready;
  assign take_in     = in_valid & in_ready;
  assign resolve     = take_in & (state == RUN);
  assign do_redirect = resolve & taken & ~misalign;

  // FSM state and shadow counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      shadow_cnt <= '0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
    end
  end

  // Enter the shadow window after a redirect and leave when the counter expires.
  always_comb begin
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    case (state)
      RUN: begin
        if (do_redirect && (SHADOW_CYCLES > 0)) begin
          state_nxt      = SHADOW;
          shadow_cnt_nxt = SHADOW_INIT;
        end
      end
      SHADOW: begin
        shadow_cnt_nxt = shadow_cnt - SCW'(1);
        if (shadow_cnt == SCW'(1)) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt      = RUN;
        shadow_cnt_nxt = '0;
      end
    endcase
  end

  // Result register: load on a resolved transfer, hold while stalled, drop when consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_misalign   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) begin
        redirect_pc <= target;
      end
      if (resolve) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_taken    <= taken;
        out_target   <= target;
        out_misalign <= misalign;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Saturating statistics; squashed inputs never reach here because resolve excludes SHADOW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (resolve && (branch_count != {CNT_W{1'b1}})) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (resolve && taken && (taken_count != {CNT_W{1'b1}})) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int SHADOW = 2;
  localparam int CMAX   = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [11:0] in_imm;
  logic [2:0]  in_branch_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_ov;
  logic [31:0] m_pc;
  bit          m_taken;
  logic [31:0] m_tgt;
  bit          m_mis;
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_shadow;
  int          m_bc;
  int          m_tc;

  branch_resolve_unit #(.XLEN(32), .SHADOW_CYCLES(SHADOW), .CNT_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pc             (in_pc),
    .in_rs1_data       (in_rs1_data),
    .in_rs2_data       (in_rs2_data),
    .in_imm            (in_imm),
    .in_branch_control (in_branch_control),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_taken         (out_taken),
    .out_target        (out_target),
    .out_misalign      (out_misalign),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .branch_count      (branch_count),
    .taken_count       (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (c)
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return a == b;
    endcase
  endfunction

  task automatic model_reset();
    m_ov = 0; m_pc = '0; m_taken = 0; m_tgt = '0; m_mis = 0;
    m_rv = 0; m_rpc = '0; m_shadow = 0; m_bc = 0; m_tc = 0;
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("out_pc", out_pc, m_pc);
    chk("out_taken", out_taken, m_taken);
    chk("out_target", out_target, m_tgt);
    chk("out_misalign", out_misalign, m_mis);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("branch_count", branch_count, m_bc);
    chk("taken_count", taken_count, m_tc);
  endtask

  // one clock: drive inputs, check in_ready, advance model, check outputs after the edge
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [11:0] imm, input logic [2:0] code, input bit ordy, input bit do_chk);
    bit          rdy;
    bit          t;
    int          off;
    logic [31:0] tgt;
    in_valid = v; in_pc = pc; in_rs1_data = a; in_rs2_data = b;
    in_imm = imm; in_branch_control = code; out_ready = ordy;
    #1;
    rdy = (m_shadow > 0) || !m_ov || ordy;
    if (do_chk) chk("in_ready", in_ready, rdy);
    if (v && rdy && m_shadow == 0) begin
      t   = ref_taken(code, a, b);
      off = $signed({imm, 1'b0});
      tgt = pc + off;
      m_ov = 1; m_pc = pc; m_taken = t; m_tgt = tgt; m_mis = t && tgt[1];
      m_rv = t && !tgt[1];
      if (m_rv) m_rpc = tgt;
      if (m_bc < CMAX) m_bc++;
      if (t && m_tc < CMAX) m_tc++;
      if (m_rv && SHADOW > 0) m_shadow = SHADOW;
    end else begin
      if (m_shadow > 0) m_shadow--;
      if (ordy) m_ov = 0;
      m_rv = 0;
    end
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle(input bit ordy);
    step(0, 32'h0, 32'h0, 32'h0, 12'h0, 3'd0, ordy, 1);
  endtask

  initial begin
    int bc_before;
    reset = 1'b1;
    in_valid = 0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_branch_control = '0; out_ready = 0;
    model_reset();
    #12;
    check_all();
    chk("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // basic BEQ taken
    step(1, 32'h100, 32'd5, 32'd5, 12'h004, 3'd0, 1, 1);
    chk("beq_taken", out_taken, 1'b1);
    chk("beq_target", out_target, 32'h108);
    chk("beq_redirect", redirect_valid, 1'b1);
    chk("beq_redirect_pc", redirect_pc, 32'h108);
    chk("beq_bc", branch_count, 16'd1);
    chk("beq_tc", taken_count, 16'd1);
    idle(1);
    chk("redirect_one_cycle", redirect_valid, 1'b0);
    idle(1);

    // signed vs unsigned compare
    step(1, 32'h200, 32'hFFFF_FFFF, 32'd1, 12'h010, 3'd4, 1, 1);
    chk("blt_taken", out_taken, 1'b1);
    idle(1);
    idle(1);
    step(1, 32'h300, 32'hFFFF_FFFF, 32'd1, 12'h010, 3'd6, 1, 1);
    chk("bltu_not_taken", out_taken, 1'b0);
    chk("bltu_no_redirect", redirect_valid, 1'b0);
    bc_before = m_bc;
    step(1, 32'h304, 32'd7, 32'd7, 12'h008, 3'd0, 1, 1);
    chk("still_run_after_bltu", branch_count, bc_before + 1);
    idle(1);
    idle(1);

    // shadow squash with in_valid held high
    step(1, 32'h400, 32'd3, 32'd3, 12'h020, 3'd0, 1, 1);
    bc_before = m_bc;
    step(1, 32'h500, 32'd9, 32'd9, 12'h004, 3'd0, 1, 1);
    chk("shadow_drop1", branch_count, bc_before);
    step(1, 32'h504, 32'd9, 32'd9, 12'h004, 3'd0, 1, 1);
    chk("shadow_drop2", branch_count, bc_before);
    step(1, 32'h508, 32'd9, 32'd9, 12'h004, 3'd0, 1, 1);
    chk("after_shadow_bc", branch_count, bc_before + 1);
    chk("after_shadow_redirect", redirect_pc, 32'h510);
    idle(1);
    idle(1);

    // stall for 3 cycles, then consume with a new input on the same edge
    step(1, 32'h600, 32'd1, 32'd1, 12'h004, 3'd1, 0, 1);
    step(1, 32'h700, 32'd1, 32'd1, 12'h004, 3'd1, 0, 1);
    step(1, 32'h700, 32'd1, 32'd1, 12'h004, 3'd1, 0, 1);
    step(1, 32'h700, 32'd1, 32'd1, 12'h004, 3'd1, 0, 1);
    chk("stall_hold_pc", out_pc, 32'h600);
    step(1, 32'h700, 32'd1, 32'd1, 12'h004, 3'd1, 1, 1);
    chk("stall_release_pc", out_pc, 32'h700);
    chk("stall_release_valid", out_valid, 1'b1);

    // target wrap and misalignment
    step(1, 32'h0, 32'd2, 32'd2, 12'h800, 3'd0, 1, 1);
    chk("wrap_target", out_target, 32'hFFFF_F000);
    idle(1);
    idle(1);
    step(1, 32'h100, 32'd2, 32'd2, 12'h001, 3'd0, 1, 1);
    chk("mis_target", out_target, 32'h102);
    chk("mis_flag", out_misalign, 1'b1);
    chk("mis_no_redirect", redirect_valid, 1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 8);
      b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 8));
      step($urandom_range(0, 3) != 0, $urandom, a, b, 12'($urandom), 3'($urandom),
           $urandom_range(0, 3) != 0, 1);
    end

    // reset in the middle of a shadow window with a stalled result
    idle(1);
    idle(1);
    idle(1);
    step(1, 32'h800, 32'd4, 32'd4, 12'h010, 3'd0, 0, 1);
    step(1, 32'h900, 32'd4, 32'd4, 12'h010, 3'd0, 0, 1);
    chk("pre_reset_valid", out_valid, 1'b1);
    in_valid = 0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("mid_reset_in_ready", in_ready, 1'b1);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1, 32'hA00, 32'd4, 32'd4, 12'h010, 3'd0, 1, 1);
    chk("run_after_reset", branch_count, 16'd1);
    idle(1);
    idle(1);

    // counter saturation using misaligned taken branches (no shadow)
    for (int i = 0; i < 70000; i++) begin
      step(1, 32'h100, 32'd2, 32'd2, 12'h001, 3'd0, 1, 0);
    end
    check_all();
    chk("sat_branch", branch_count, 16'hFFFF);
    chk("sat_taken", taken_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
